ssf_reg_writer: RTL and testbench

- Clocked front end for the SSF cartridge bank/SRAM control registers.
- Synchronises the asynchronous Mega Drive bus strobes (tme, lwr, cas0, ce_0) into the cart-local clock domain and glitch-filters them.
- Decodes lower-byte writes to $A130F0-$A130FF and holds the register file: SRAM enable/writable flags plus bank registers 1-7.
- Sits directly upstream of the address mapper, which consumes these registers as its bank table and SRAM control.

---
 rtl/ssf_reg_writer.sv | 144 ++++++++++++++
 tb/tb_ssf_reg_writer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ssf_reg_writer.sv
// SSF bank/SRAM control register front end: synchronises and glitch-filters the
// Mega Drive bus strobes, then commits lower-byte writes into the register file.
module ssf_reg_writer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 3,
    parameter logic [4:0]  REG_BASE      = 5'b01111
) (
    input  logic        clk,
    input  logic        vres,
    input  logic [8:1]  cart_address,
    input  logic [7:0]  cart_data,
    input  logic        tme,
    input  logic        lwr,
    input  logic        cas0,
    input  logic        ce_0,
    output logic        sram_enabled,
    output logic        sram_writable,
    output logic [41:0] banks,
    output logic        wr_strobe,
    output logic [2:0]  wr_index
);

    localparam int unsigned CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);
    localparam logic [41:0] BANK_RESET = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] QUAL    = 2'd1;
    localparam logic [1:0] COMMIT  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    // Strobe order within each stage: {tme, lwr, cas0, ce_0}
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic                        tme_s, lwr_s, cas0_s, ce_0_s;

    logic [8:1]       addr_q;
    logic [5:0]       data_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [5:0]       wdat_q, wdat_d;
    logic             qual;

    logic unused_data;
    assign unused_data = ^cart_data[7:6];

    assign {tme_s, lwr_s, cas0_s, ce_0_s} = sync_q[SYNC_STAGES-1];

    assign qual = !tme_s && !lwr_s && cas0_s && ce_0_s && (addr_q[8:4] == REG_BASE);

    always_ff @(posedge clk or negedge vres) begin
        if (!vres) begin
            sync_q <= '1;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {tme, lwr, cas0, ce_0}};
            addr_q <= cart_address;
            data_q <= cart_data[5:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        case (state_q)
            IDLE: begin
                if (qual) begin
                    state_d = QUAL;
                    cnt_d   = CNT_W'(1);
                    idx_d   = addr_q[3:1];
                    wdat_d  = data_q;
                end
            end
            QUAL: begin
                if (!qual) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    idx_d  = addr_q[3:1];
                    wdat_d = data_q;
                end else begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = RELEASE;
                cnt_d   = '0;
            end
            RELEASE: begin
                // Hold here until the bus cycle ends so a long lwr commits only once
                if (lwr_s || tme_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge vres) begin
        if (!vres) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
        end
    end

    always_ff @(posedge clk or negedge vres) begin
        if (!vres) begin
            sram_enabled  <= 1'b0;
            sram_writable <= 1'b0;
            banks         <= BANK_RESET;
            wr_strobe     <= 1'b0;
            wr_index      <= 3'd0;
        end else begin
            wr_strobe <= (state_q == COMMIT);
            if (state_q == COMMIT) begin
                wr_index <= idx_q;
                if (idx_q == 3'd0) begin
                    sram_enabled  <= wdat_q[0];
                    sram_writable <= wdat_q[1];
                end
                for (int n = 1; n < 8; n++) begin
                    if (idx_q == 3'(n)) begin
                        banks[6*n-6 +: 6] <= wdat_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ssf_reg_writer.sv
// Directed table-driven bench for ssf_reg_writer with hand-written reset corner cases.
module tb_ssf_reg_writer;

    logic        clk = 1'b0;
    logic        vres = 1'b1;
    logic [7:0]  cart_address = 8'h00;
    logic [7:0]  cart_data = 8'h00;
    logic        tme = 1'b1;
    logic        lwr = 1'b1;
    logic        cas0 = 1'b1;
    logic        ce_0 = 1'b1;
    logic        sram_enabled;
    logic        sram_writable;
    logic [41:0] banks;
    logic        wr_strobe;
    logic [2:0]  wr_index;

    int n_cmp = 0;
    int n_fail = 0;

    ssf_reg_writer #(
        .SYNC_STAGES(2),
        .FILTER_CYCLES(3),
        .REG_BASE(5'b01111)
    ) dut (
        .clk(clk),
        .vres(vres),
        .cart_address(cart_address),
        .cart_data(cart_data),
        .tme(tme),
        .lwr(lwr),
        .cas0(cas0),
        .ce_0(ce_0),
        .sram_enabled(sram_enabled),
        .sram_writable(sram_writable),
        .banks(banks),
        .wr_strobe(wr_strobe),
        .wr_index(wr_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        tme;
        logic        lwr;
        logic        cas0;
        logic        ce_0;
        int          hold;
        int          exp_pulses;
        int          exp_lat;
        logic        exp_en;
        logic        exp_wr;
        logic [2:0]  exp_idx;
        logic [41:0] exp_banks;
    } vec_t;

    localparam logic [41:0] RST_BANKS = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1};

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        tme  = 1'b1;
        lwr  = 1'b1;
        cas0 = 1'b1;
        ce_0 = 1'b1;
    endtask

    task automatic apply_vec(input int id, input vec_t v);
        int pulses;
        int first;
        string tag;
        pulses = 0;
        first  = 0;
        tag    = $sformatf("v%0d", id);
        cart_address = v.addr;
        cart_data    = v.data;
        tme  = v.tme;
        lwr  = v.lwr;
        cas0 = v.cas0;
        ce_0 = v.ce_0;
        for (int c = 1; c <= v.hold + 8; c++) begin
            if (c == v.hold + 1) idle_bus();
            tick();
            if (wr_strobe === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        chk({tag, "_pulses"}, 64'(pulses), 64'(v.exp_pulses));
        if (v.exp_lat != 0) chk({tag, "_latency"}, 64'(first), 64'(v.exp_lat));
        chk({tag, "_banks"}, 64'(banks), 64'(v.exp_banks));
        chk({tag, "_sram_en"}, 64'(sram_enabled), 64'(v.exp_en));
        chk({tag, "_sram_wr"}, 64'(sram_writable), 64'(v.exp_wr));
        chk({tag, "_wr_index"}, 64'(wr_index), 64'(v.exp_idx));
    endtask

    initial begin
        int pulses;
        vec_t post;

        // Address bits are [8:1]: {addr[8:4], index}
        vecs[0] = '{8'h7B, 8'h2A, 1'b0, 1'b0, 1'b1, 1'b1, 10, 1, 7, 1'b0, 1'b0, 3'd3,
                    {6'd7, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'd1}};
        vecs[1] = '{8'h78, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 10, 1, 7, 1'b1, 1'b1, 3'd0,
                    {6'd7, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'd1}};
        vecs[2] = '{8'h78, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 10, 1, 7, 1'b1, 1'b0, 3'd0,
                    {6'd7, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'd1}};
        vecs[3] = '{8'h7D, 8'h3F, 1'b0, 1'b0, 1'b1, 1'b0, 10, 0, 0, 1'b1, 1'b0, 3'd0,
                    {6'd7, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'd1}};
        vecs[4] = '{8'h7D, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 10, 0, 0, 1'b1, 1'b0, 3'd0,
                    {6'd7, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'd1}};
        vecs[5] = '{8'h7D, 8'h3F, 1'b1, 1'b0, 1'b1, 1'b1, 10, 0, 0, 1'b1, 1'b0, 3'd0,
                    {6'd7, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'd1}};
        vecs[6] = '{8'h75, 8'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 10, 0, 0, 1'b1, 1'b0, 3'd0,
                    {6'd7, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'd1}};
        // Glitch: only two synchronised qualifying cycles
        vecs[7] = '{8'h7D, 8'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0, 0, 1'b1, 1'b0, 3'd0,
                    {6'd7, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'd1}};
        vecs[8] = '{8'h7F, 8'h15, 1'b0, 1'b0, 1'b1, 1'b1, 50, 1, 7, 1'b1, 1'b0, 3'd7,
                    {6'h15, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'd1}};
        // Bits [7:6] of bank data dropped
        vecs[9] = '{8'h79, 8'hC9, 1'b0, 1'b0, 1'b1, 1'b1, 10, 1, 7, 1'b1, 1'b0, 3'd1,
                    {6'h15, 6'd6, 6'd5, 6'd4, 6'h2A, 6'd2, 6'h09}};

        #2 vres = 1'b0;
        #1;
        chk("async_reset_banks", 64'(banks), 64'(RST_BANKS));
        tick();
        tick();
        vres = 1'b1;
        tick();
        tick();
        chk("reset_banks", 64'(banks), 64'(RST_BANKS));
        chk("reset_sram_en", 64'(sram_enabled), 64'(1'b0));
        chk("reset_sram_wr", 64'(sram_writable), 64'(1'b0));
        chk("reset_wr_strobe", 64'(wr_strobe), 64'(1'b0));
        chk("reset_wr_index", 64'(wr_index), 64'(3'd0));

        for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

        // Reset while a write to bank 2 is still being filtered
        cart_address = 8'h7A;
        cart_data    = 8'h11;
        tme = 1'b0;
        lwr = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        vres = 1'b0;
        #1;
        chk("midqual_async_sram_en", 64'(sram_enabled), 64'(1'b0));
        chk("midqual_async_banks", 64'(banks), 64'(RST_BANKS));
        idle_bus();
        tick();
        tick();
        vres = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (wr_strobe === 1'b1) pulses++;
        end
        chk("midqual_pulses", 64'(pulses), 64'(0));
        chk("midqual_banks", 64'(banks), 64'(RST_BANKS));
        chk("midqual_wr_index", 64'(wr_index), 64'(3'd0));

        // A fresh write after reset must still go through
        post = '{8'h7A, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 10, 1, 7, 1'b0, 1'b0, 3'd2,
                 {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'h11, 6'd1}};
        apply_vec(10, post);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
